// File: rtl/xs3_bcd_serial_conv.sv
// Digit-serial Excess-3 <-> BCD word converter with per-digit invalid-code flags.
// One digit is converted per clock, least-significant first, behind valid/ready handshakes.
module xs3_bcd_serial_conv #(
  parameter int NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NDIGITS-1:0]   in_data,
  input  logic                   in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NDIGITS-1:0]   out_data,
  output logic [NDIGITS-1:0]     out_err_mask,
  output logic                   out_err
);

  localparam int W     = 4 * NDIGITS;
  localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [W-1:0]       sreg;
  logic               mode;
  logic [4:0]         conv;
  logic               last;
  logic [W-1:0]       data_nxt;
  logic [NDIGITS-1:0] mask_nxt;

  // Returns {err, digit}; an invalid code yields err=1 and digit 0xF.
  function automatic logic [4:0] convert_digit(input logic [3:0] d, input logic m);
    logic [4:0] r;
    if (!m) begin
      if (d >= 4'h3 && d <= 4'hC) r = {1'b0, d - 4'h3};
      else                        r = {1'b1, 4'hF};
    end else begin
      if (d <= 4'h9) r = {1'b0, d + 4'h3};
      else           r = {1'b1, 4'hF};
    end
    return r;
  endfunction

  always_comb begin
    conv     = convert_digit(sreg[3:0], mode);
    last     = (cnt == CNT_W'(NDIGITS - 1));
    data_nxt = out_data;
    mask_nxt = out_err_mask;
    for (int i = 0; i < NDIGITS; i++) begin
      if (cnt == CNT_W'(i)) begin
        data_nxt[4*i +: 4] = conv[3:0];
        mask_nxt[i]        = conv[4];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) state_nxt = CONV;
      end
      CONV: begin
        if (last) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_err = |out_err_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      out_data     <= '0;
      out_err_mask <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg         <= in_data;
            mode         <= in_mode;
            out_data     <= '0;
            out_err_mask <= '0;
            cnt          <= '0;
          end
        end
        CONV: begin
          // The shift register always presents the current digit in its low nibble.
          sreg         <= sreg >> 4;
          out_data     <= data_nxt;
          out_err_mask <= mask_nxt;
          cnt          <= last ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
